// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// accum_pkg : shared types for the multi-channel accumulator bank
// Rev 1.0   : initial release
// ============================================================================
package accum_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_MOD  = 2'd1,
        MODE_SAT  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    // Channel id width; a single-channel bank still carries a 1-bit id.
    function automatic int calc_cw(input int ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_alu.sv
`default_nettype none
// ============================================================================
// accum_alu : combinational update of one accumulator value for one operation
// Rev 1.0   : initial release
// ============================================================================
module accum_alu
    import accum_pkg::*;
#(
    parameter int    DW   = 8,
    parameter int    M    = 200,
    parameter mode_e MODE = MODE_MOD
) (
    input  logic [DW-1:0] acc_i,
    input  logic [DW-1:0] data_i,
    input  op_e           op_i,
    output logic [DW-1:0] next_o,
    output logic          flag_o,
    output logic          err_o
);

    localparam logic [DW:0] C_M     = (DW+1)'(M);
    localparam logic [DW:0] C_M_MAX = C_M - 1'b1;

    logic [DW:0] sum_w;
    logic [DW:0] diff_w;
    logic        range_bad_w;

    assign sum_w       = {1'b0, acc_i} + {1'b0, data_i};
    assign diff_w      = {1'b0, acc_i} - {1'b0, data_i};
    assign range_bad_w = (MODE != MODE_WRAP) && ({1'b0, data_i} >= C_M);

    always_comb begin
        next_o = acc_i;
        flag_o = 1'b0;
        err_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                if (MODE == MODE_MOD && sum_w >= C_M) begin
                    next_o = DW'(sum_w - C_M);
                    flag_o = 1'b1;
                end else if (MODE == MODE_SAT && sum_w > C_M_MAX) begin
                    next_o = C_M_MAX[DW-1:0];
                    flag_o = 1'b1;
                end else begin
                    next_o = sum_w[DW-1:0];
                    flag_o = sum_w[DW];
                end
            end
            OP_SUB: begin
                next_o = diff_w[DW-1:0];
                flag_o = diff_w[DW];
                // Borrow: both operands are below M, so one add of M lands in range.
                if (diff_w[DW]) begin
                    if (MODE == MODE_MOD) begin
                        next_o = DW'(diff_w + C_M);
                    end else if (MODE == MODE_SAT) begin
                        next_o = '0;
                    end
                end
            end
            OP_LOAD: next_o = data_i;
            OP_CLR:  next_o = '0;
            default: next_o = acc_i;
        endcase
        if (range_bad_w && op_i != OP_CLR) begin
            next_o = acc_i;
            flag_o = 1'b0;
            err_o  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/accum_bank.sv
`default_nettype none
// ============================================================================
// accum_bank : CH-channel accumulator bank with one shared update port
// Rev 1.0    : initial release
// ============================================================================
module accum_bank
    import accum_pkg::*;
#(
    parameter int    CH   = 4,
    parameter int    DW   = 8,
    parameter int    M    = 200,
    parameter mode_e MODE = MODE_MOD,
    localparam int   CW   = calc_cw(CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_all,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  op_e           in_op,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic [DW-1:0] out_acc,
    output logic          out_flag,
    output logic          out_err
);

    logic [DW-1:0] acc_q [CH];
    logic [DW-1:0] cur_w;
    logic [DW-1:0] alu_next_w;
    logic          alu_flag_w;
    logic          alu_err_w;
    logic          ch_ok_w;
    logic          accept_w;

    logic          out_valid_q;
    logic [CW-1:0] out_ch_q;
    logic [DW-1:0] out_acc_q;
    logic          out_flag_q;
    logic          out_err_q;

    assign in_ready = !clr_all && (!out_valid_q || out_ready);
    assign accept_w = in_valid && in_ready;
    assign ch_ok_w  = ({1'b0, in_ch} < (CW+1)'(CH));

    always_comb begin
        cur_w = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == CW'(i)) cur_w = acc_q[i];
        end
    end

    accum_alu #(
        .DW   (DW),
        .M    (M),
        .MODE (MODE)
    ) u_alu (
        .acc_i  (cur_w),
        .data_i (in_data),
        .op_i   (in_op),
        .next_o (alu_next_w),
        .flag_o (alu_flag_w),
        .err_o  (alu_err_w)
    );

    // Channel state is written in the accept cycle, so the next op sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < CH; i++) acc_q[i] <= '0;
        end else if (accept_w && !alu_err_w) begin
            for (int i = 0; i < CH; i++) begin
                if (in_ch == CW'(i)) acc_q[i] <= alu_next_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_acc_q   <= '0;
            out_flag_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (accept_w) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= in_ch;
            out_acc_q   <= ch_ok_w ? alu_next_w : '0;
            out_flag_q  <= ch_ok_w && alu_flag_w;
            out_err_q   <= !ch_ok_w || alu_err_w;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_acc   = out_acc_q;
    assign out_flag  = out_flag_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_bank.sv
`default_nettype none
// ============================================================================
// tb_accum_bank : MOD, SAT and WRAP banks driven by one directed stream
// Rev 1.0       : initial release
// ============================================================================
module tb_accum_bank;
    import accum_pkg::*;

    localparam int CH = 5;
    localparam int DW = 8;
    localparam int M  = 200;
    localparam int CW = 3;
    localparam int NI = 3;   // 0: MOD, 1: SAT, 2: WRAP

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_all = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [CW-1:0] in_ch = '0;
    op_e           in_op = OP_ADD;
    logic [DW-1:0] in_data = '0;

    logic          o_ready [NI];
    logic          o_valid [NI];
    logic          o_flag  [NI];
    logic          o_err   [NI];
    logic [CW-1:0] o_ch    [NI];
    logic [DW-1:0] o_acc   [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic mode_e mode_of(input int k);
        case (k)
            0:       return MODE_MOD;
            1:       return MODE_SAT;
            default: return MODE_WRAP;
        endcase
    endfunction

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            accum_bank #(.CH(CH), .DW(DW), .M(M), .MODE(mode_of(k))) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr_all   (clr_all),
                .in_valid  (in_valid),
                .in_ready  (o_ready[k]),
                .in_ch     (in_ch),
                .in_op     (in_op),
                .in_data   (in_data),
                .out_valid (o_valid[k]),
                .out_ready (out_ready),
                .out_ch    (o_ch[k]),
                .out_acc   (o_acc[k]),
                .out_flag  (o_flag[k]),
                .out_err   (o_err[k])
            );
        end
    endgenerate

    // Reference model: integer channel values and one pending result beat per bank.
    int mdl [NI][CH];
    bit ev [NI];
    int ech [NI];
    int eacc [NI];
    bit eflag [NI];
    bit eerr [NI];

    function automatic void calc(input int k, input int acc, input op_e op, input int d,
                                 output int nxt, output bit fl, output bit er);
        nxt = acc; fl = 1'b0; er = 1'b0;
        if (k != 2 && op != OP_CLR && d >= M) begin
            er = 1'b1;
            return;
        end
        case (op)
            OP_ADD: begin
                nxt = acc + d;
                if (k == 2 && nxt >= 256)        begin nxt = nxt - 256; fl = 1'b1; end
                else if (k == 0 && nxt >= M)     begin nxt = nxt - M;   fl = 1'b1; end
                else if (k == 1 && nxt > M - 1)  begin nxt = M - 1;     fl = 1'b1; end
            end
            OP_SUB: begin
                nxt = acc - d;
                if (nxt < 0) begin
                    fl  = 1'b1;
                    nxt = (k == 2) ? nxt + 256 : (k == 0) ? nxt + M : 0;
                end
            end
            OP_LOAD: nxt = d;
            default: nxt = 0;
        endcase
    endfunction

    initial begin
        int nxt;
        bit fl, er, rdy;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    for (int c = 0; c < CH; c++) mdl[k][c] = 0;
                    ev[k] = 0; ech[k] = 0; eacc[k] = 0; eflag[k] = 0; eerr[k] = 0;
                end else begin
                    rdy = !clr_all && (!ev[k] || out_ready);
                    if (clr_all) for (int c = 0; c < CH; c++) mdl[k][c] = 0;
                    if (in_valid && rdy) begin
                        ev[k]  = 1;
                        ech[k] = int'(in_ch);
                        if (int'(in_ch) >= CH) begin
                            eacc[k] = 0; eflag[k] = 0; eerr[k] = 1;
                        end else begin
                            calc(k, mdl[k][int'(in_ch)], in_op, int'(in_data), nxt, fl, er);
                            if (!er) mdl[k][int'(in_ch)] = nxt;
                            eacc[k] = nxt; eflag[k] = fl; eerr[k] = er;
                        end
                    end else if (out_ready) begin
                        ev[k] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("in_ready[%0d]", k), 32'(o_ready[k]), int'(!clr_all && (!ev[k] || out_ready)));
                chk($sformatf("out_valid[%0d]", k), 32'(o_valid[k]), int'(ev[k]));
                if (ev[k]) begin
                    chk($sformatf("out_ch[%0d]", k), 32'(o_ch[k]), ech[k]);
                    chk($sformatf("out_acc[%0d]", k), 32'(o_acc[k]), eacc[k]);
                    chk($sformatf("out_flag[%0d]", k), 32'(o_flag[k]), int'(eflag[k]));
                    chk($sformatf("out_err[%0d]", k), 32'(o_err[k]), int'(eerr[k]));
                end
            end
        end
    end

    task automatic issue(input int ch, input op_e op, input int d);
        in_ch    = CW'(ch);
        in_op    = op;
        in_data  = DW'(d);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input int k, input int acc, input bit fl, input bit er);
        chk({name, ".valid"}, 32'(o_valid[k]), 1);
        chk({name, ".acc"},   32'(o_acc[k]),   acc);
        chk({name, ".flag"},  32'(o_flag[k]),  int'(fl));
        chk({name, ".err"},   32'(o_err[k]),   int'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset.valid", 32'(o_valid[k]), 0);
            chk("reset.acc",   32'(o_acc[k]),   0);
            chk("reset.ch",    32'(o_ch[k]),    0);
            chk("reset.flag",  32'(o_flag[k]),  0);
            chk("reset.err",   32'(o_err[k]),   0);
            chk("reset.ready", 32'(o_ready[k]), 1);
        end
        rst_n = 1'b1;

        issue(0, OP_ADD, 150);  lit("mod_add150", 0, 150, 0, 0);
        issue(0, OP_ADD, 100);  lit("mod_add100", 0, 50, 1, 0);
        issue(1, OP_ADD, 0);    lit("mod_ch1_zero", 0, 0, 0, 0);
        issue(1, OP_LOAD, 10);  lit("mod_load10", 0, 10, 0, 0);
        issue(1, OP_SUB, 30);   lit("mod_sub30", 0, 180, 1, 0);
        issue(1, OP_ADD, 200);  lit("mod_add200_err", 0, 180, 0, 1);
        issue(1, OP_ADD, 0);    lit("mod_ch1_kept", 0, 180, 0, 0);

        issue(2, OP_ADD, 150);
        issue(2, OP_ADD, 100);  lit("sat_add", 1, 199, 1, 0);
        issue(2, OP_SUB, 250);  lit("sat_sub_err", 1, 199, 0, 1);
        issue(2, OP_LOAD, 5);
        issue(2, OP_SUB, 9);    lit("sat_sub_floor", 1, 0, 1, 0);

        issue(3, OP_ADD, 150);
        issue(3, OP_ADD, 150);  lit("wrap_add", 2, 44, 1, 0);

        issue(5, OP_ADD, 1);    lit("bad_ch", 0, 0, 0, 1);
        chk("bad_ch.ch", 32'(o_ch[0]), 5);

        // Backpressure: a second op waits while the first result is held.
        issue(0, OP_ADD, 1);    lit("bp_first", 0, 51, 0, 0);
        out_ready = 1'b0;
        in_ch = 3'd0; in_op = OP_ADD; in_data = 8'd7; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_ready", 32'(o_ready[0]), 0);
            lit("bp_hold", 0, 51, 0, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lit("bp_resume", 0, 58, 0, 0);

        clr_all = 1'b1;
        #1;
        chk("clr_ready", 32'(o_ready[0]), 0);
        @(posedge clk);
        #1;
        clr_all = 1'b0;
        issue(0, OP_ADD, 1);    lit("after_clr", 0, 1, 0, 0);

        // Reset with a held beat outstanding.
        issue(1, OP_ADD, 3);    lit("pre_rst", 0, 3, 0, 0);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) chk("rst_async.valid", 32'(o_valid[k]), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(1, OP_ADD, 0);    lit("rst_ch1", 0, 0, 0, 0);
        issue(0, OP_ADD, 0);    lit("rst_ch0", 0, 0, 0, 0);
        issue(2, OP_ADD, 0);    lit("rst_sat_ch2", 1, 0, 0, 0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
